axi4lite_sram_responder: RTL and testbench
==========================================

// Module: axi4lite_sram_responder
// PURPOSE
// - AXI4-Lite responder (slave) that terminates the core's data/instruction bus: byte-addressed, word-wide on-chip SRAM.
// - Independent write (AW/W/B) and read (AR/R) channel engines; byte strobes; configurable read wait states.
// - No response codes are carried on the bus; accesses outside the window are flagged on a sticky error output.
// PARAMETERS
// - BASE_ADDR   32'h0000_0000  byte address of word 0
// - MEM_WORDS   1024           number of 32-bit words (power of two)
// - READ_WAIT   0              extra cycles between AR handshake and Rvalid (0..15)
// PORTS
// - clk      in   1   single clock, all state on rising edge
// - rstn     in   1   reset, asynchronous assert, active-low
// - AWdata   in   32  write byte address
// - AWvalid  in   1   write address valid
// - AWready  out  1   write address ready
// - AWprot   in   3   ignored
// - Wdata    in   32  write data
// - Wstrb    in   4   byte lane enables, bit i -> Wdata[8i+7:8i]
// - Wvalid   in   1   write data valid
// - Wready   out  1   write data ready
// - Bvalid   out  1   write response valid
// - Bready   in   1   write response accepted
// - ARdata   in   32  read byte address
// - ARvalid  in   1   read address valid
// - ARready  out  1   read address ready
// - ARprot   in   3   ignored
// - Rdata    out  32  read data
// - Rvalid   out  1   read data valid
// - RReady   in   1   read data accepted
// - oob_err  out  1   sticky: an out-of-window access occurred
// BEHAVIOUR
// - Reset (rstn=0, async): AWready=Wready=ARready=0, Bvalid=Rvalid=0, Rdata=0, oob_err=0, both FSMs idle. SRAM contents not reset.
// - Readies are registered; they rise on the first clk edge after rstn deasserts.
// - Address map: hit iff BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS; index = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
// - Write FSM: W_IDLE -> W_COLLECT -> W_RESP.
//   - AWready=1 until AW captured; Wready=1 until W captured; AW and W accepted in either order or same cycle.
//   - At the edge where the second of the pair handshakes (edge k), enter W_RESP.
//   - Edge k+1: SRAM bytes with Wstrb=1 updated; Bvalid=1.
//   - Bvalid held until Bready; on Bvalid&Bready return to W_IDLE with both readies back to 1 next cycle.
//   - Wstrb=0: handshake and Bvalid complete normally, no byte written.
//   - Miss: write discarded, oob_err set.
// - Read FSM: R_IDLE -> R_WAIT -> R_DATA.
//   - ARready=1 in R_IDLE only; AR handshake captures address, ARready drops, counter loads READ_WAIT.
//   - Counter decrements per cycle in R_WAIT; SRAM sampled on the edge entering R_DATA.
//   - Rvalid rises 1+READ_WAIT cycles after the AR handshake edge.
//   - Rdata/Rvalid stable until RReady; on Rvalid&RReady return to R_IDLE.
//   - Miss: Rdata=32'h0000_0000, oob_err set.
// - Simultaneous events:
//   - Read sample and write commit to the same word on the same edge: read returns OLD data.
//   - A read sampling after the commit edge returns NEW data.
// - Channels never block each other. Max one outstanding transaction per channel.
// - Reset mid-transaction: pending write not committed if rstn falls before the commit edge; Bvalid/Rvalid drop immediately.
// - oob_err clears only on reset.
// STRUCTURE
// - Shared include mriscv_axi_defs.vh: FSM state encodings (W_IDLE/W_COLLECT/W_RESP, R_IDLE/R_WAIT/R_DATA) and address-window check macro, reused by other bus responders.
// - Sub-module sram_bytewise: MEM_WORDS x 32 array, 1 write port with 4-bit byte enable, 1 synchronous read port, no reset.
// - Top holds both channel FSMs, read wait counter, window decode, oob_err.
// TESTING
// - Same-cycle AW=0x10/W=0xCAFEBABE, Wstrb=4'hF, Bready=1 -> Bvalid 1 cycle later, 1 cycle wide; read 0x10 -> Rdata=0xCAFEBABE after 1+READ_WAIT cycles.
// - W before AW by 3 cycles, Wstrb=4'b0010, Wdata=0x0000AB00 over 0x11223344 -> word reads 0x1122AB44; Wready low while waiting for AW.
// - Bready held low 5 cycles -> Bvalid and the write FSM held; AWready=Wready=0 throughout.
// - RReady held low 4 cycles -> Rvalid, Rdata stable, ARready=0; READ_WAIT=3 -> Rvalid 4 cycles after AR handshake.
// - Read of BASE_ADDR+4*MEM_WORDS -> Rdata=0, oob_err=1; write there -> Bvalid normal, SRAM unchanged, oob_err stays 1 until rstn.
// - Concurrent write/read of 0x20 with commit and sample on the same edge -> old data returned; rstn pulse mid-write -> no commit, all outputs at reset values.

Source files
------------

// File: rtl/axi4lite_sram_responder_pkg.sv
// Shared bus-responder definitions: channel FSM encodings and the address-window check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package axi4lite_sram_responder_pkg;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_COLLECT = 2'd1,
        W_RESP    = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    localparam int unsigned WAIT_W = 4;

    // Subtract in 33 bits so addresses below the base borrow out instead of wrapping into the window.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned words);
        logic [32:0] off;
        logic [32:0] span;
        off  = {1'b0, addr} - {1'b0, base};
        span = {1'b0, words} << 2;
        return (off[32] == 1'b0) && (off < span);
    endfunction

endpackage

// File: rtl/axi4lite_sram_responder_sram.sv
// Word-wide SRAM, one byte-enabled write port and one registered read port, contents not reset.
// Latency: read data valid the cycle after re; write lands on the edge where we is high.
// Backpressure: none; always accepts both ports every cycle.
module sram_bytewise #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Read and write share one block so a same-edge collision returns the pre-write word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi4lite_sram_responder.sv
// AXI4-Lite responder onto on-chip SRAM with independent write and read engines and a sticky window-miss flag.
// Latency: Bvalid 1 cycle after the later of AW/W handshakes; Rvalid 1+READ_WAIT cycles after AR handshake.
// Backpressure: one transaction per channel; readies stay low until Bready / RReady retire the response.
module axi4lite_sram_responder
    import axi4lite_sram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned READ_WAIT = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] AWdata,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [2:0]  AWprot,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    input  logic        Wvalid,
    output logic        Wready,
    output logic        Bvalid,
    input  logic        Bready,
    input  logic [31:0] ARdata,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [2:0]  ARprot,
    output logic [31:0] Rdata,
    output logic        Rvalid,
    input  logic        RReady,
    output logic        oob_err
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    wr_state_e   w_state_q, w_state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        w_commit;
    logic        w_hit;

    rd_state_e   r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        r_hit_q, r_hit_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic        r_sample;

    logic        oob_q, oob_d;

    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] w_off, r_off;
    logic [31:0] sram_rdata;
    logic        unused_bits;

    assign aw_hs = AWvalid & awready_q;
    assign w_hs  = Wvalid & wready_q;
    assign ar_hs = ARvalid & arready_q;
    assign w_hit = addr_hit(aw_addr_q, BASE_ADDR, MEM_WORDS);

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        aw_addr_d = aw_addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        w_commit  = 1'b0;
        case (w_state_q)
            W_IDLE, W_COLLECT: begin
                if (aw_hs) begin
                    aw_addr_d = AWdata;
                    aw_got_d  = 1'b1;
                end
                if (w_hs) begin
                    wdata_d = Wdata;
                    wstrb_d = Wstrb;
                    w_got_d = 1'b1;
                end
                if (aw_got_d && w_got_d) begin
                    w_state_d = W_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    w_state_d = (aw_got_d || w_got_d) ? W_COLLECT : W_IDLE;
                    awready_d = !aw_got_d;
                    wready_d  = !w_got_d;
                end
            end
            W_RESP: begin
                // First W_RESP cycle commits; Bvalid appears together with the written data.
                if (!bvalid_q) begin
                    w_commit = 1'b1;
                    bvalid_d = 1'b1;
                end else if (Bready) begin
                    bvalid_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_addr_q <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            aw_addr_q <= aw_addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        r_hit_d   = r_hit_q;
        ar_addr_d = ar_addr_q;
        cnt_d     = cnt_q;
        r_sample  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_addr_d = ARdata;
                    r_hit_d   = addr_hit(ARdata, BASE_ADDR, MEM_WORDS);
                    cnt_d     = WAIT_W'(READ_WAIT);
                    arready_d = 1'b0;
                    r_state_d = R_WAIT;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_WAIT: begin
                if (cnt_q == '0) begin
                    r_sample  = 1'b1;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            R_DATA: begin
                if (RReady) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_hit_q   <= 1'b0;
            ar_addr_q <= 32'h0;
            cnt_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            r_hit_q   <= r_hit_d;
            ar_addr_q <= ar_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign oob_d = oob_q | (w_commit & !w_hit) | (r_sample & !r_hit_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= oob_d;
        end
    end

    assign w_off = aw_addr_q - BASE_ADDR;
    assign r_off = ar_addr_q - BASE_ADDR;

    sram_bytewise #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (w_commit & w_hit),
        .be    (wstrb_q),
        .waddr (w_off[IDX_W+1:2]),
        .wdata (wdata_q),
        .re    (r_sample & r_hit_q),
        .raddr (r_off[IDX_W+1:2]),
        .rdata (sram_rdata)
    );

    // Misses never touch the SRAM read register, so mask to zero rather than expose a stale word.
    assign Rdata   = (rvalid_q && r_hit_q) ? sram_rdata : 32'h0;
    assign Rvalid  = rvalid_q;
    assign ARready = arready_q;
    assign AWready = awready_q;
    assign Wready  = wready_q;
    assign Bvalid  = bvalid_q;
    assign oob_err = oob_q;

    assign unused_bits = ^{AWprot, ARprot, w_off[1:0], w_off[31:IDX_W+2],
                           r_off[1:0], r_off[31:IDX_W+2]};

endmodule

// File: tb/tb_axi4lite_sram_responder.sv
// Directed and randomized bench for axi4lite_sram_responder against a word-array reference model.
module tb_axi4lite_sram_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WORDS = 1024;
    localparam int unsigned RW    = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] AWdata;
    logic        AWvalid;
    logic        AWready;
    logic [2:0]  AWprot;
    logic [31:0] Wdata;
    logic [3:0]  Wstrb;
    logic        Wvalid;
    logic        Wready;
    logic        Bvalid;
    logic        Bready;
    logic [31:0] ARdata;
    logic        ARvalid;
    logic        ARready;
    logic [2:0]  ARprot;
    logic [31:0] Rdata;
    logic        Rvalid;
    logic        RReady;
    logic        oob_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [int unsigned];
    bit          ref_oob;

    always #5 clk = ~clk;

    axi4lite_sram_responder #(
        .BASE_ADDR (BASE),
        .MEM_WORDS (WORDS),
        .READ_WAIT (RW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .AWdata  (AWdata),
        .AWvalid (AWvalid),
        .AWready (AWready),
        .AWprot  (AWprot),
        .Wdata   (Wdata),
        .Wstrb   (Wstrb),
        .Wvalid  (Wvalid),
        .Wready  (Wready),
        .Bvalid  (Bvalid),
        .Bready  (Bready),
        .ARdata  (ARdata),
        .ARvalid (ARvalid),
        .ARready (ARready),
        .ARprot  (ARprot),
        .Rdata   (Rdata),
        .Rvalid  (Rvalid),
        .RReady  (RReady),
        .oob_err (oob_err)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        return (off >= 0) && (off < 4 * longint'(WORDS));
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        return (a - BASE) / 4;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!in_win(a)) begin
            ref_oob = 1'b1;
            return;
        end
        w = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        ref_mem[word_of(a)] = w;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_win(a)) begin
            ref_oob = 1'b1;
            return 32'h0;
        end
        return ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 32'h0;
    endfunction

    task automatic hs_loop();
        int n;
        logic a_f, w_f;
        n = 0;
        while ((AWvalid || Wvalid) && n < 64) begin
            a_f = AWvalid & AWready;
            w_f = Wvalid & Wready;
            tick();
            n++;
            if (a_f) AWvalid = 1'b0;
            if (w_f) Wvalid = 1'b0;
        end
        check("aw_w_accepted", {30'd0, AWvalid, Wvalid}, 32'd0);
    endtask

    // lead > 0: W handshakes lead cycles before AW; lead < 0: AW first.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int b_hold);
        bit first_w;
        int l;
        first_w = (lead > 0);
        l       = (lead < 0) ? -lead : lead;
        AWdata  = addr;
        AWprot  = 3'($urandom);
        Wdata   = data;
        Wstrb   = strb;
        Bready  = (b_hold == 0);
        if (l == 0) begin
            AWvalid = 1'b1;
            Wvalid  = 1'b1;
        end else begin
            if (first_w) Wvalid = 1'b1;
            else         AWvalid = 1'b1;
            hs_loop();
            for (int i = 1; i < l; i++) begin
                check("first_ready_low", {30'd0, AWready, Wready}, first_w ? 32'd2 : 32'd1);
                tick();
            end
            check("first_ready_low", {30'd0, AWready, Wready}, first_w ? 32'd2 : 32'd1);
            if (first_w) AWvalid = 1'b1;
            else         Wvalid = 1'b1;
        end
        hs_loop();
        check("b_at_pair_edge", {29'd0, Bvalid, AWready, Wready}, 32'd0);
        tick();
        model_write(addr, data, strb);
        check("b_rise", {29'd0, Bvalid, AWready, Wready}, 32'd4);
        check("oob_after_write", {31'd0, oob_err}, {31'd0, ref_oob});
        for (int i = 0; i < b_hold; i++) begin
            tick();
            check("b_hold", {29'd0, Bvalid, AWready, Wready}, 32'd4);
        end
        Bready = 1'b1;
        tick();
        check("b_done", {29'd0, Bvalid, AWready, Wready}, 32'd3);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_hold, output logic [31:0] got);
        int n;
        logic a_f;
        logic [31:0] exp;
        ARdata  = addr;
        ARprot  = 3'($urandom);
        ARvalid = 1'b1;
        RReady  = (r_hold == 0);
        n   = 0;
        a_f = 1'b0;
        while (!a_f && n < 64) begin
            a_f = ARready;
            tick();
            n++;
        end
        ARvalid = 1'b0;
        check("ar_drop", {31'd0, ARready}, 32'd0);
        n = 0;
        while (!Rvalid && n < 64) begin
            tick();
            n++;
        end
        check("r_latency", 32'(n), 32'(1 + RW));
        exp = model_read(addr);
        got = Rdata;
        check("rdata", Rdata, exp);
        check("oob_after_read", {31'd0, oob_err}, {31'd0, ref_oob});
        for (int i = 0; i < r_hold; i++) begin
            tick();
            check("r_hold_flags", {30'd0, Rvalid, ARready}, 32'd2);
            check("r_hold_data", Rdata, exp);
        end
        RReady = 1'b1;
        tick();
        check("r_done", {30'd0, Rvalid, ARready}, 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        rstn = 1'b0;
        AWdata = '0; AWvalid = 1'b0; AWprot = '0;
        Wdata = '0; Wstrb = '0; Wvalid = 1'b0; Bready = 1'b0;
        ARdata = '0; ARvalid = 1'b0; ARprot = '0; RReady = 1'b0;
        ref_oob = 1'b0;

        // Reset values, then readies rise on the first edge after release.
        #3;
        check("rst_flags", {26'd0, AWready, Wready, ARready, Bvalid, Rvalid, oob_err}, 32'd0);
        check("rst_rdata", Rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check("ready_before_edge", {29'd0, AWready, Wready, ARready}, 32'd0);
        tick();
        check("ready_after_edge", {29'd0, AWready, Wready, ARready}, 32'd7);

        // Same-cycle AW/W, immediate Bready, read-back.
        axi_write(32'h10, 32'hCAFE_BABE, 4'hF, 0, 0);
        axi_read(32'h10, 0, got);
        check("t1_rdata", got, 32'hCAFE_BABE);

        // W three cycles ahead of AW, single byte lane.
        axi_write(32'h40, 32'h1122_3344, 4'hF, 0, 0);
        axi_write(32'h40, 32'h0000_AB00, 4'b0010, 3, 0);
        axi_read(32'h41, 0, got);
        check("t2_merge", got, 32'h1122_AB44);

        // Response backpressure on both channels, zero strobe.
        axi_write(32'h80, 32'h5566_7788, 4'hF, -2, 5);
        axi_write(32'h80, 32'hFFFF_FFFF, 4'h0, 0, 1);
        axi_read(32'h80, 4, got);
        check("t3_nostrb", got, 32'h5566_7788);
        axi_read(32'h10, 4, got);

        // Window edge: one past the last word misses, last word hits.
        axi_write(32'h0, 32'hA5A5_5A5A, 4'hF, 0, 0);
        axi_write(32'hFFC, 32'h0F0F_0F0F, 4'hF, 0, 0);
        axi_read(32'hFFC, 0, got);
        check("last_word", got, 32'h0F0F_0F0F);
        check("oob_clear", {31'd0, oob_err}, 32'd0);
        axi_read(32'h1000, 0, got);
        check("oob_rdata", got, 32'h0);
        check("oob_set", {31'd0, oob_err}, 32'd1);
        axi_write(32'h1000, 32'hDEAD_DEAD, 4'hF, 0, 0);
        axi_read(32'h0, 0, got);
        check("oob_no_alias", got, 32'hA5A5_5A5A);
        check("oob_sticky", {31'd0, oob_err}, 32'd1);

        // Randomized traffic over a small word pool.
        for (int w = 0; w < 8; w++) begin
            axi_write(32'((100 + w) * 4), $urandom, 4'hF, 0, 0);
        end
        for (int it = 0; it < 40; it++) begin
            a = 32'((100 + $urandom_range(0, 7)) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 0) begin
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 4) - 2, $urandom_range(0, 2));
            end else begin
                axi_read(a, $urandom_range(0, 2), got);
            end
        end

        // Commit and sample on the same edge: AR at h, pair at h+3, both land at h+4.
        axi_write(32'h20, 32'h0BAD_F00D, 4'hF, 0, 0);
        ARdata = 32'h20; ARvalid = 1'b1; RReady = 1'b1;
        tick();
        ARvalid = 1'b0;
        check("coll_ar_taken", {31'd0, ARready}, 32'd0);
        tick();
        tick();
        AWdata = 32'h20; Wdata = 32'h600D_CAFE; Wstrb = 4'hF;
        AWvalid = 1'b1; Wvalid = 1'b1; Bready = 1'b1;
        tick();
        AWvalid = 1'b0; Wvalid = 1'b0;
        check("coll_pre", {30'd0, Bvalid, Rvalid}, 32'd0);
        tick();
        check("coll_flags", {30'd0, Bvalid, Rvalid}, 32'd3);
        check("coll_old", Rdata, 32'h0BAD_F00D);
        model_write(32'h20, 32'h600D_CAFE, 4'hF);
        tick();
        check("coll_done", {30'd0, Bvalid, Rvalid}, 32'd0);
        axi_read(32'h20, 0, got);
        check("coll_new", got, 32'h600D_CAFE);

        // Reset between the pair handshake and the commit edge.
        axi_write(32'h30, 32'h1234_5678, 4'hF, 0, 0);
        AWdata = 32'h30; Wdata = 32'hDEAD_BEEF; Wstrb = 4'hF;
        AWvalid = 1'b1; Wvalid = 1'b1; Bready = 1'b1;
        tick();
        AWvalid = 1'b0; Wvalid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        ref_oob = 1'b0;
        check("mid_rst_flags", {26'd0, AWready, Wready, ARready, Bvalid, Rvalid, oob_err}, 32'd0);
        check("mid_rst_rdata", Rdata, 32'h0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("mid_rst_ready", {29'd0, AWready, Wready, ARready}, 32'd7);
        axi_read(32'h30, 0, got);
        check("mid_rst_nocommit", got, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
